// File: rtl/signal_field_serializer.sv
// 802.11a SIGNAL field builder: latches RATE/LENGTH into a 24-bit field with
// parity and tail, then shifts it out bit 0 first under a valid/ready handshake.
module signal_field_serializer #(
  parameter int RATE_W = 4,
  parameter int LEN_W  = 12,
  parameter int TAIL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RATE_W-1:0] rate,
  input  logic [LEN_W-1:0]  length,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_last,
  output logic              busy,
  output logic              done,
  output logic              rate_err
);

  localparam int FIELD_W = RATE_W + 1 + LEN_W + 1 + TAIL_W;
  localparam int IDX_W   = $clog2(FIELD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIELD_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   index;
  logic [FIELD_W-1:0] shreg;
  logic [FIELD_W-1:0] field;

  // Field image with bit 0 in the LSB so the shifter always emits shreg[0].
  // RATE goes out R1 first, which is the MSB of the rate code.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    field = '0;
    for (int i = 0; i < RATE_W; i++) begin
      field[i] = rate[RATE_W-1-i];
    end
    for (int j = 0; j < LEN_W; j++) begin
      field[RATE_W+1+j] = length[j];
    end
    field[RATE_W+1+LEN_W] = ^{rate, length};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      index    <= '0;
      shreg    <= '0;
      rate_err <= 1'b0;
    end else begin
      rate_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (rate[0]) begin
              shreg <= field;
              index <= '0;
              state <= SHIFT;
            end else begin
              rate_err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bit_ready) begin
            if (index == LAST_IDX) begin
              state <= DONE;
              index <= '0;
              shreg <= '0;
            end else begin
              index <= index + 1'b1;
              shreg <= shreg >> 1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bit_valid = (state == SHIFT);
  assign busy      = bit_valid;
  assign bit_out   = bit_valid & shreg[0];
  assign bit_last  = bit_valid && (index == LAST_IDX);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_signal_field_serializer.sv
// Randomized bench for signal_field_serializer: expected streams come from a
// field-layout model (or literal streams), compared bit by bit at the handshake.
module tb_signal_field_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  rate;
  logic [11:0] length;
  logic        bit_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_last;
  logic        busy;
  logic        done;
  logic        rate_err;

  int errors = 0;
  int checks = 0;

  signal_field_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rate      (rate),
    .length    (length),
    .bit_ready (bit_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .busy      (busy),
    .done      (done),
    .rate_err  (rate_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: stream bit i of the SIGNAL field, built from the field layout.
  function automatic logic [23:0] model(input logic [3:0] r, input logic [11:0] l);
    logic [23:0] s;
    int ones;
    ones = $countones(r) + $countones(l);
    s = '0;
    for (int i = 0; i < 24; i++) begin
      if (i < 4)                 s[i] = r[3-i];
      else if (i >= 5 && i <= 16) s[i] = l[i-5];
      else if (i == 17)           s[i] = (ones % 2) == 1;
    end
    return s;
  endfunction

  // Character k of the string is stream bit k.
  function automatic logic [23:0] from_str(input string str);
    logic [23:0] s;
    s = '0;
    for (int i = 0; i < 24; i++) s[i] = (str[i] == "1");
    return s;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge after done.
  task automatic send_field(input logic [3:0] r, input logic [11:0] l,
                            input logic [23:0] exp, input int pct, input bit mid_start);
    int   idx;
    int   cyc;
    bit   ready;
    bit   prev_ready;
    logic prev_bit;
    bit   pulsed;
    rate = r; length = l; start = 1'b1; bit_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    idx = 0; cyc = 0; prev_ready = 1'b1; prev_bit = 1'b0; pulsed = 1'b0;
    while (idx < 24) begin
      if (cyc > 2000) begin
        check("timeout", 0, 1);
        break;
      end
      check("valid", bit_valid, 1);
      check($sformatf("bit%0d", idx), bit_out, exp[idx]);
      check("last", bit_last, idx == 23);
      if (!prev_ready) check("hold", bit_out, prev_bit);
      if (mid_start && idx == 10 && !pulsed) begin
        start = 1'b1;
        rate = 4'($urandom) | 4'b0001;
        length = 12'($urandom);
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      bit_ready = ready;
      prev_bit = bit_out;
      prev_ready = ready;
      @(negedge clk);
      if (ready) idx++;
      cyc++;
    end
    start = 1'b0; bit_ready = 1'b0;
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    check("valid_fall", bit_valid, 0);
    check("last_fall", bit_last, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic reject(input logic [3:0] r);
    rate = r; length = 12'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rate_err", rate_err, 1);
    check("rej_busy", busy, 0);
    check("rej_valid", bit_valid, 0);
    @(negedge clk);
    check("rate_err_once", rate_err, 0);
    check("rej_busy2", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] t1;
    logic [23:0] t2;
    logic [3:0]  r;
    logic [11:0] l;
    t1 = from_str("110100010011000000000000");
    t2 = from_str("111101000000000001000000");

    rst = 1'b0; start = 1'b0; rate = '0; length = '0; bit_ready = 1'b0;
    #3;
    check("rst_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bit", bit_out, 0);
    check("rst_last", bit_last, 0);
    check("rst_err", rate_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // T1 / T2: literal streams, always ready; back-to-back.
    send_field(4'b1101, 12'd100, t1, 100, 1'b0);
    send_field(4'b1111, 12'd1, t2, 100, 1'b0);
    // T3: T1 with random backpressure.
    send_field(4'b1101, 12'd100, t1, 50, 1'b0);
    // T4: rejected rate.
    reject(4'b1100);
    // T5: start and input changes mid-field.
    send_field(4'b1101, 12'd100, t1, 70, 1'b1);

    // T6: reset in flight at index 12.
    rate = 4'b1101; length = 12'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bit_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("pre_rst_bit12", bit_out, t1[12]);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", bit_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bit", bit_out, 0);
    check("mid_rst_last", bit_last, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", rate_err, 0);
    bit_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    send_field(4'b1101, 12'd100, t1, 100, 1'b0);

    // Randomized fields against the layout model.
    for (int k = 0; k < 12; k++) begin
      r = 4'($urandom);
      l = 12'($urandom);
      if (k % 4 == 3) begin
        r[0] = 1'b0;
        reject(r);
      end else begin
        r[0] = 1'b1;
        send_field(r, l, model(r, l), (k % 3 == 0) ? 100 : 30 + $urandom_range(0, 60), k[0]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
